// File: rtl/spi_shared_master.sv
// Round-robin sequencing SPI master (mode 0) for the shared board SPI bus.
// One complete transaction runs at a time; request fields are latched at grant.
module spi_shared_master #(
   parameter int NREQ   = 2,
   parameter int NSLAVE = 9,
   parameter int WIDTH  = 32,
   parameter int CLKDIV = 2
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic [NREQ-1:0]          req,
   input  logic [NREQ*NSLAVE-1:0]   req_ss,
   input  logic [NREQ*6-1:0]        req_len,
   input  logic [NREQ*WIDTH-1:0]    req_data,
   output logic [NREQ-1:0]          gnt,
   output logic [NREQ-1:0]          done,
   output logic [WIDTH-1:0]         rdata,
   output logic                     busy,
   output logic [NSLAVE-1:0]        sen,
   output logic                     sclk,
   output logic                     mosi,
   input  logic                     miso
);

   localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
   localparam int LW = $clog2(WIDTH + 1);
   localparam int CW = $clog2(2 * CLKDIV + 1);

   typedef enum logic [2:0] {IDLE, SETUP, SHIFT_LO, SHIFT_HI, HOLD, DONE} state_t;

   state_t            state, state_nxt;
   logic [PW-1:0]     sel, next_pri, arb_sel;
   logic              arb_hit;
   logic [NSLAVE-1:0] ss_q;
   logic [WIDTH-1:0]  tx_sh, rx_sh;
   logic [LW-1:0]     bits_left, len_eff, sh_amt;
   logic [CW-1:0]     div_cnt, phase_len;
   logic              phase_last;
   logic [5:0]        len_sel;

   logic [NSLAVE-1:0] ss_arr   [NREQ];
   logic [5:0]        len_arr  [NREQ];
   logic [WIDTH-1:0]  data_arr [NREQ];

   for (genvar g = 0; g < NREQ; g++) begin : g_unpack
      assign ss_arr[g]   = req_ss[g*NSLAVE +: NSLAVE];
      assign len_arr[g]  = req_len[g*6 +: 6];
      assign data_arr[g] = req_data[g*WIDTH +: WIDTH];
   end

   // Pick the pending requester closest (cyclically) to the priority pointer.
   always_comb begin : p_arb
      int d;
      int best;
      d       = 0;
      best    = NREQ;
      arb_sel = '0;
      arb_hit = |req;
      for (int i = 0; i < NREQ; i++) begin
         if (req[i]) begin
            d = i - int'(next_pri);
            if (d < 0) d = d + NREQ;
            if (d < best) begin
               best    = d;
               arb_sel = PW'(i);
            end
         end
      end
   end

   // A length of zero (or beyond WIDTH) means a full-width transfer.
   assign len_sel = len_arr[arb_sel];
   always_comb begin
      len_eff = LW'(WIDTH);
      if (len_sel != '0 && 32'(len_sel) <= 32'(WIDTH)) len_eff = LW'(len_sel);
   end
   assign sh_amt = LW'(WIDTH) - len_eff;

   // HOLD spans the low half of the final bit plus the enable hold time.
   assign phase_len  = (state == HOLD) ? CW'(2 * CLKDIV) : CW'(CLKDIV);
   assign phase_last = (div_cnt == phase_len - 1'b1);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:     if (arb_hit) state_nxt = SETUP;
         SETUP:    if (phase_last) state_nxt = SHIFT_HI;
         SHIFT_HI: if (phase_last) state_nxt = (bits_left == '0) ? HOLD : SHIFT_LO;
         SHIFT_LO: if (phase_last) state_nxt = SHIFT_HI;
         HOLD:     if (phase_last) state_nxt = DONE;
         DONE:     state_nxt = IDLE;
         default:  state_nxt = IDLE;
      endcase
   end

   always_comb begin
      gnt  = '0;
      done = '0;
      busy = 1'b0;
      sen  = '1;
      sclk = 1'b0;
      mosi = 1'b0;
      case (state)
         SETUP, SHIFT_LO, SHIFT_HI, HOLD: begin
            busy = 1'b1;
            gnt  = NREQ'(1) << sel;
            sen  = ~ss_q;
            sclk = (state == SHIFT_HI);
            mosi = tx_sh[WIDTH-1];
         end
         DONE:    done = NREQ'(1) << sel;
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sel       <= '0;
         next_pri  <= '0;
         ss_q      <= '0;
         tx_sh     <= '0;
         rx_sh     <= '0;
         bits_left <= '0;
         div_cnt   <= '0;
         rdata     <= '0;
      end else begin
         div_cnt <= (state_nxt != state || state == IDLE) ? '0 : div_cnt + 1'b1;
         case (state)
            IDLE: if (arb_hit) begin
               sel       <= arb_sel;
               ss_q      <= ss_arr[arb_sel];
               tx_sh     <= data_arr[arb_sel] << sh_amt;
               rx_sh     <= '0;
               bits_left <= len_eff;
            end
            // miso is captured on the edge that raises sclk
            SETUP, SHIFT_LO: if (phase_last) begin
               rx_sh     <= {rx_sh[WIDTH-2:0], miso};
               bits_left <= bits_left - 1'b1;
            end
            SHIFT_HI: if (phase_last && bits_left != '0) tx_sh <= tx_sh << 1;
            HOLD:     if (phase_last) rdata <= rx_sh;
            DONE: begin
               if (sel == PW'(NREQ - 1)) next_pri <= '0;
               else                      next_pri <= sel + 1'b1;
            end
            default: ;
         endcase
      end
   end

endmodule
